ffd_shift_reg_univ: RTL and testbench
=====================================

Name: ffd_shift_reg_univ

Overview:
- Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit universal register.
- Supports hold, parallel load, clear, shift and rotate in both directions, all gated by enable.
- An auto-shift sequencer performs N shifts or rotations from a single start pulse and reports busy/done.
- Used as a generic storage and serialiser building block in the lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of nshift and of the internal shift counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  clock enable; no state change in a cycle where enable=0, except reset.
- mode  input  3  operation select; encoding under Behaviour.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- start  input  1  launches auto-shift sequence; sampled only in IDLE with enable=1.
- nshift  input  CNT_W  number of auto shifts; sampled with start.
- q  output  WIDTH  register contents.
- sout  output  1  registered copy of the last bit shifted or rotated out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when an auto sequence completes.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - q=0, sout=0, busy=0, done=0, counter=0, state=IDLE, latched mode=000.
- Mode encoding:
  - 000 hold
  - 001 load: q<=d
  - 010 shift left: q<={q[W-2:0],sin}, sout<=q[W-1]
  - 011 shift right: q<={sin,q[W-1:1]}, sout<=q[0]
  - 100 rotate left: q<={q[W-2:0],q[W-1]}, sout<=q[W-1]
  - 101 rotate right: q<={q[0],q[W-1:1]}, sout<=q[0]
  - 110 clear: q<=0, sout unchanged
  - 111 hold (reserved)
- sout changes only on shift or rotate operations.
- States: IDLE, RUN.
- IDLE, enable=1, start=0: apply mode with latency 1 (q updates on the next rising edge).
- IDLE, enable=1, start=1 (start has priority over the manual op in the same cycle):
  - mode in {010,011,100,101} and nshift>0: latch mode and nshift into the counter; go to RUN; busy=1 from the next edge; no shift on the start cycle.
  - nshift=0: stay IDLE, done=1 for one cycle, q unchanged.
  - mode not a shift/rotate: start ignored and treated as the manual op for that cycle (load, clear or hold).
- RUN, enable=1:
  - Perform one latched op per cycle, using live sin; decrement the counter.
  - On the edge where the counter goes 1->0: the final shift occurs, state goes to IDLE, busy=0 and done=1 on that same edge.
  - Exactly nshift shifts occur.
- RUN, enable=0: pause; q, counter and busy hold; done stays 0.
- RUN ignores mode, d and start inputs.
- done is high for exactly one cycle and is cleared on the next edge regardless of enable.
- Total latency, start to done with enable held high: nshift+1 edges.
- nshift > WIDTH is legal: shifts continue, so rotates wrap and shifts fill entirely with sin.

Optional Feature:
- Macro: FFD_SHIFT_PARITY_EN.
- Defined:
  - Extra output port par (1 bit) = XOR reduction of q, purely combinational from q.
  - Reads 0 during and after reset.
- Undefined: port par absent; no other behaviour changes.

Test Plan:
- Reset mid-RUN, then load: WIDTH=8, load d=8'hA5, start rotate-left nshift=5, assert reset after 2 shifts -> q=0, busy=0, done=0 immediately. After release, mode=001 d=8'h3C enable=1 -> q=8'h3C next edge.
- Enable gating: mode=001 d=8'hFF enable=0 for 3 cycles -> q holds 8'h3C. Set enable=1 -> q=8'hFF next edge.
- Manual shift right: q=8'h81, mode=011 sin=0, one edge -> q=8'h40, sout=1. Mode=010 sin=1 -> q=8'h81, sout=0.
- Auto rotate: q=8'hA5, start mode=101 nshift=4 -> busy high 4 cycles, then q=8'h5A and done pulses 1 cycle, 5 edges after start.
- Pause: same as the auto-rotate case with enable dropped for 2 cycles mid-run -> q frozen during the pause, total 4 shifts, done 7 edges after start. Also start with nshift=0 -> done next edge, q unchanged, busy never high.
- Overshift: q=8'hFF, start mode=010 sin=0 nshift=10 -> q=8'h00, sout=0 at done. If FFD_SHIFT_PARITY_EN is defined, par=0 at this point and par=0 for q=8'hA5.

Source files
------------

// File: rtl/ffd_shift_reg_univ.sv
// ---------------------------------------------------------------------------
// ffd_shift_reg_univ
//   WIDTH-bit universal register: hold, parallel load, clear, shift and rotate
//   in both directions, all gated by a clock enable. An auto-shift sequencer
//   runs nshift shifts/rotates from one start pulse and reports busy/done.
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   CNT_W   width of nshift and of the internal shift counter
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   enable  clock enable (reset still acts when low)
//   mode    000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror,
//           110 clear, 111 hold
//   d       parallel load data
//   sin     serial input for shift modes
//   start   launches an auto sequence (sampled in IDLE with enable=1)
//   nshift  number of auto shifts, sampled with start
//   q       register contents
//   sout    last bit shifted or rotated out
//   busy    high while the sequencer is running
//   done    one-cycle pulse when an auto sequence completes
//   par     XOR reduction of q (only with FFD_SHIFT_PARITY_EN defined)
//
// Build option
//   FFD_SHIFT_PARITY_EN  adds the combinational parity output par.
// ---------------------------------------------------------------------------
module ffd_shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef FFD_SHIFT_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lmode_q, lmode_d;
  logic [WIDTH-1:0] q_d;
  logic             sout_d;
  logic             done_d;

  // Only shifts and rotates can be run by the sequencer.
  function automatic logic is_shift_op(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  function automatic logic [WIDTH-1:0] op_q(input logic [2:0]       m,
                                            input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] din,
                                            input logic             s);
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      MODE_LOAD:  r = din;
      MODE_SHL:   r = {cur[WIDTH-2:0], s};
      MODE_SHR:   r = {s, cur[WIDTH-1:1]};
      MODE_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      MODE_CLEAR: r = '0;
      default:    r = cur;
    endcase
    return r;
  endfunction

  // sout only moves on shift/rotate; every other op leaves it alone.
  function automatic logic op_sout(input logic [2:0]       m,
                                   input logic [WIDTH-1:0] cur,
                                   input logic             cur_sout);
    logic r;
    r = cur_sout;
    case (m)
      MODE_SHL, MODE_ROL: r = cur[WIDTH-1];
      MODE_SHR, MODE_ROR: r = cur[0];
      default:            r = cur_sout;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q;
    sout_d  = sout;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    // done is a pulse: it drops on the next edge whatever enable does.
    done_d  = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start && is_shift_op(mode)) begin
            if (nshift == '0) begin
              done_d = 1'b1;
            end else begin
              // Start cycle only arms the sequencer; the first shift is next edge.
              lmode_d = mode;
              cnt_d   = nshift;
              state_d = ST_RUN;
            end
          end else begin
            q_d    = op_q(mode, q, d, sin);
            sout_d = op_sout(mode, q, sout);
          end
        end
        ST_RUN: begin
          q_d    = op_q(lmode_q, q, d, sin);
          sout_d = op_sout(lmode_q, q, sout);
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lmode_q <= MODE_HOLD;
      q       <= '0;
      sout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
      q       <= q_d;
      sout    <= sout_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);

`ifdef FFD_SHIFT_PARITY_EN
  assign par = ^q;
`endif

endmodule

// File: tb/tb_ffd_shift_reg_univ.sv
module tb_ffd_shift_reg_univ;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic       start;
  logic [3:0] nshift;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;
`ifdef FFD_SHIFT_PARITY_EN
  logic       par;
`endif

  int n_cmp;
  int n_fail;

  ffd_shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .d      (d),
    .sin    (sin),
    .start  (start),
    .nshift (nshift),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
`ifdef FFD_SHIFT_PARITY_EN
    ,
    .par    (par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] nsh;
    logic [7:0] eq;
    logic       es;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic [2:0] m, input logic [7:0] dd,
                     input logic s, input logic st, input logic [3:0] n,
                     input logic [7:0] eq, input logic es, input logic eb,
                     input logic ed);
    vec_t v;
    v.en = en; v.mode = m; v.d = dd; v.sin = s; v.start = st; v.nsh = n;
    v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] m, input logic [7:0] dd,
                       input logic s, input logic st, input logic [3:0] n);
    enable = en; mode = m; d = dd; sin = s; start = st; nshift = n;
  endtask

  // One clock: inputs already driven, wait for the edge, sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                         input logic eb, input logic ed);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_sout"}, 32'(sout), 32'(es));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
`ifdef FFD_SHIFT_PARITY_EN
    chk({tag, "_par"}, 32'(par), 32'(^eq));
`endif
  endtask

  // ---------------- behavioural reference (plain integer arithmetic) -------
  int         m_q;
  int         m_sout;
  int         m_run;
  int         m_left;
  logic [2:0] m_mode;
  int         m_done;

  function automatic logic shift_like(input logic [2:0] m);
    return m >= 3'd2 && m <= 3'd5;
  endfunction

  task automatic m_apply(input logic [2:0] m, input int dd, input int s);
    case (m)
      3'd1: m_q = dd;
      3'd2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
      3'd3: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128; end
      3'd4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
      3'd5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
      3'd6: m_q = 0;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_q = 0; m_sout = 0; m_run = 0; m_left = 0; m_mode = 3'd0; m_done = 0;
  endtask

  task automatic m_step(input logic en, input logic [2:0] m, input logic [7:0] dd,
                        input logic s, input logic st, input logic [3:0] n);
    m_done = 0;
    if (en) begin
      if (m_run == 0) begin
        if (st && shift_like(m) && n != 0) begin
          m_run = 1; m_left = int'(n); m_mode = m;
        end else if (st && shift_like(m)) begin
          m_done = 1;
        end else begin
          m_apply(m, int'(dd), int'(s));
        end
      end else begin
        m_apply(m_mode, int'(dd), int'(s));
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);

    // ---------------- vector table ----------------
    add(1, 3'b001, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(0, 3'b001, 8'hFF, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(0, 3'b001, 8'hFF, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(0, 3'b001, 8'hFF, 0, 0, 0, 8'h3C, 0, 0, 0);
    add(1, 3'b001, 8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0);
    add(1, 3'b001, 8'h81, 0, 0, 0, 8'h81, 0, 0, 0);
    add(1, 3'b011, 8'h00, 0, 0, 0, 8'h40, 1, 0, 0);
    add(1, 3'b010, 8'h00, 1, 0, 0, 8'h81, 0, 0, 0);
    add(1, 3'b100, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0);
    add(1, 3'b101, 8'h00, 0, 0, 0, 8'h81, 1, 0, 0);
    add(1, 3'b110, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    add(1, 3'b111, 8'h55, 0, 0, 0, 8'h00, 1, 0, 0);
    add(1, 3'b001, 8'hA5, 0, 0, 0, 8'hA5, 1, 0, 0);
    // auto rotate right x4; mode/d/start during the run must be ignored
    add(1, 3'b101, 8'h00, 0, 1, 4, 8'hA5, 1, 1, 0);
    add(1, 3'b001, 8'h00, 0, 1, 7, 8'hD2, 1, 1, 0);
    add(1, 3'b001, 8'h00, 0, 1, 7, 8'h69, 0, 1, 0);
    add(1, 3'b001, 8'h00, 0, 1, 7, 8'hB4, 1, 1, 0);
    add(1, 3'b001, 8'h00, 0, 1, 7, 8'h5A, 0, 0, 1);
    add(0, 3'b000, 8'h00, 0, 0, 0, 8'h5A, 0, 0, 0);
    // same run with a two-cycle pause
    add(1, 3'b001, 8'hA5, 0, 0, 0, 8'hA5, 0, 0, 0);
    add(1, 3'b101, 8'h00, 0, 1, 4, 8'hA5, 0, 1, 0);
    add(1, 3'b000, 8'h00, 0, 0, 0, 8'hD2, 1, 1, 0);
    add(0, 3'b000, 8'h00, 0, 0, 0, 8'hD2, 1, 1, 0);
    add(0, 3'b000, 8'h00, 0, 0, 0, 8'hD2, 1, 1, 0);
    add(1, 3'b000, 8'h00, 0, 0, 0, 8'h69, 0, 1, 0);
    add(1, 3'b000, 8'h00, 0, 0, 0, 8'hB4, 1, 1, 0);
    add(1, 3'b000, 8'h00, 0, 0, 0, 8'h5A, 0, 0, 1);
    // nshift = 0: immediate done, q unchanged, never busy
    add(1, 3'b010, 8'h00, 1, 1, 0, 8'h5A, 0, 0, 1);
    add(1, 3'b000, 8'h00, 0, 0, 0, 8'h5A, 0, 0, 0);
    // start with a non-shift mode acts as the manual op
    add(1, 3'b001, 8'h77, 0, 1, 3, 8'h77, 0, 0, 0);
    // overshift: 10 left shifts of FF with sin=0
    add(1, 3'b001, 8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0);
    add(1, 3'b010, 8'h00, 0, 1, 10, 8'hFF, 0, 1, 0);
    begin
      int qq;
      qq = 255;
      for (int k = 1; k <= 10; k++) begin
        logic es;
        es = (qq >= 128);
        qq = (qq * 2) % 256;
        add(1, 3'b000, 8'h00, 0, 0, 0, 8'(qq), es, (k != 10), (k == 10));
      end
    end

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin, tbl[i].start, tbl[i].nsh);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].es, tbl[i].eb, tbl[i].ed);
    end

    // ---------------- reset in the middle of a run ----------------
    drive(1, 3'b001, 8'hA5, 0, 0, 0); tick();
    drive(1, 3'b100, 8'h00, 0, 1, 5); tick();
    chk("midrst_busy", 32'(busy), 32'd1);
    drive(1, 3'b000, 8'h00, 0, 0, 0); tick();
    tick();
    chk("midrst_q2", 32'(q), 32'h96);
    #2 reset = 1'b1;
    #1;
    chk_all("midrst_async", 8'h00, 0, 0, 0);
    #1 reset = 1'b0;
    drive(1, 3'b001, 8'h3C, 0, 0, 0); tick();
    chk_all("midrst_load", 8'h3C, 0, 0, 0);
    drive(1, 3'b000, 8'h00, 0, 0, 0); tick();
    chk_all("midrst_idle", 8'h3C, 0, 0, 0);

    // ---------------- randomized run against the reference ----------------
    reset = 1'b1;
    #2 reset = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       r_en, r_sin, r_st;
      logic [2:0] r_m;
      logic [7:0] r_d;
      logic [3:0] r_n;
      r_en  = ($urandom_range(0, 3) != 0);
      r_m   = 3'($urandom_range(0, 7));
      r_d   = 8'($urandom);
      r_sin = 1'($urandom);
      r_st  = ($urandom_range(0, 5) == 0);
      r_n   = 4'($urandom_range(0, 15));
      drive(r_en, r_m, r_d, r_sin, r_st, r_n);
      m_step(r_en, r_m, r_d, r_sin, r_st, r_n);
      tick();
      chk_all($sformatf("rand%0d", c), 8'(m_q), 1'(m_sout), 1'(m_run), 1'(m_done));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        m_reset();
        chk_all($sformatf("rand%0d_rst", c), 8'(m_q), 1'(m_sout), 1'(m_run), 1'(m_done));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
